// File: rtl/cacheline_burst_adaptor.sv
// Cacheline <-> burst adaptor: turns one 256-bit line read/write into a
// fixed-length beat burst on the memory side and reassembles read beats.
module cacheline_burst_adaptor #(
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned BURSTS      = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    localparam int unsigned LINE_WIDTH = BURST_WIDTH * BURSTS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);

    localparam int unsigned OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam int unsigned CNT_W    = $clog2(BURSTS);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [LINE_WIDTH-1:0]   wbuf;
    logic                    last_beat;
    logic                    unused_offset;

    // Byte offset within the line is dropped when forming the memory address.
    assign unused_offset = ^address_i[OFFSET_W-1:0];

    assign last_beat = (cnt == CNT_W'(BURSTS - 1));

    // Write beat is muxed straight from the registered buffer and counter.
    assign burst_o = wbuf[cnt*BURST_WIDTH +: BURST_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wbuf      <= '0;
            line_o    <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_o <= 1'b0;
                    // Read wins when both requests are raised together.
                    if (read_i) begin
                        address_o <= {address_i[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        cnt       <= '0;
                        read_o    <= 1'b1;
                        state     <= READ;
                    end else if (write_i) begin
                        address_o <= {address_i[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        cnt       <= '0;
                        wbuf      <= line_i;
                        write_o   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    resp_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Sits between the last-level cache and the burst memory model (ParamMemory, 4 x 64-bit beats) in the mp3 top.
- Converts one 256-bit cacheline read/write into a 4-beat burst transaction and reassembles read beats into a line.
- Single outstanding transaction; the cache holds its request until it sees a resp_o pulse.

Parameters:
- BURST_WIDTH, 64, bits per memory beat.
- BURSTS, 4, beats per cacheline.
- ADDR_WIDTH, 32, address width.
- LINE_WIDTH is derived as BURST_WIDTH*BURSTS (256) and is not overridable. The line offset width is log2(LINE_WIDTH/8) (5).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- address_i  in  ADDR_WIDTH  cache request address.
- read_i  in  1  cache line read request.
- write_i  in  1  cache line write request.
- line_i  in  LINE_WIDTH  line to write.
- line_o  out  LINE_WIDTH  assembled read line.
- resp_o  out  1  transaction-complete pulse.
- address_o  out  ADDR_WIDTH  line-aligned memory address.
- read_o  out  1  memory burst read.
- write_o  out  1  memory burst write.
- burst_o  out  BURST_WIDTH  write beat data.
- burst_i  in  BURST_WIDTH  read beat data.
- resp_i  in  1  memory beat valid/accept.

Behaviour:
- FSM states: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state/counter.
- Reset (asynchronous, immediate):
  - state=IDLE, beat counter=0.
  - read_o=0, write_o=0, resp_o=0.
  - address_o=0, line_o=0, internal write buffer=0.
  - burst_o=0 because the buffer is 0.
- IDLE:
  - On a clock edge with read_i=1: latch {address_i[ADDR_WIDTH-1:5], 5'b0} into address_o, clear the counter, go to READ.
  - Else on write_i=1: also latch line_i into the write buffer, go to WRITE.
  - If read_i and write_i are both 1, the read wins and the write is ignored. This case is illegal from the cache; the bench flags it but the DUT must not hang.
  - resp_i in IDLE or DONE is ignored.
- READ:
  - read_o=1.
  - Each cycle with resp_i=1: line_o[counter*64 +: 64] <= burst_i, counter++.
  - On the edge where counter==BURSTS-1 and resp_i=1, go to DONE.
  - Wait cycles (resp_i=0) between beats are allowed and simply stall.
- WRITE:
  - write_o=1, burst_o = buffer[counter*64 +: 64] (combinational from the registered counter).
  - Each cycle with resp_i=1, memory consumes burst_o and counter++.
  - Exit to DONE on the final beat, same rule as READ.
- DONE:
  - resp_o=1 for exactly one cycle, read_o=0, write_o=0, then IDLE.
  - line_o is valid from the resp_o cycle and holds until the next read overwrites it. A write never modifies line_o.
- Request inputs while in READ/WRITE/DONE are ignored; address_i and line_i may change freely after acceptance.
- A new request seen in IDLE on the cycle right after DONE starts a new transaction, giving back-to-back operation with one IDLE cycle between.
- Latency, with memory returning beats on consecutive cycles starting k cycles after read_o/write_o rises:
  - read_o/write_o rises 1 cycle after the request is sampled.
  - resp_o rises 1 cycle after the 4th resp_i.
- Counter width is log2(BURSTS). It wraps to 0 on the final beat; no other wrap occurs.
- Reset mid-transaction aborts: read_o/write_o drop asynchronously, no resp_o is issued, and partially assembled line_o contents are cleared to 0.
- No X propagation: with burst_i/line_i known, every output is known in every cycle after the first reset.

Test Plan:
- Read, beats contiguous:
  - Stimulus: read_i at address_i=0x0000_1234; memory returns 0x1111..11, 0x2222..22, 0x3333..33, 0x4444..44.
  - Required: address_o=0x0000_1220, read_o high exactly 4 resp cycles plus latency, resp_o single pulse, line_o=0x4444..44_3333..33_2222..22_1111..11.
- Write with stalls:
  - Stimulus: line_i = beats A0..A3; memory inserts 2 idle cycles between beats 1 and 2.
  - Required: burst_o holds A1 through the stall; the memory model captures A0,A1,A2,A3 in order; write_o drops after the 4th resp_i; one resp_o.
- Back-to-back:
  - Stimulus: write to 0x40 then read of 0x40 issued on the cycle after resp_o.
  - Required: the read returns the written line; exactly 2 resp_o pulses; line_o unchanged by the write phase.
- Simultaneous read_i=write_i=1 in IDLE:
  - Required: only read_o asserts, write_o stays 0, transaction completes normally.
- Reset after the 2nd read beat:
  - Required: read_o=0 and line_o=0 immediately on rst rise, no resp_o; a following read completes correctly.
- Spurious resp_i=1 for 3 cycles while IDLE:
  - Required: counter stays 0, no state change, no resp_o; the next read still collects 4 fresh beats.
